// File: rtl/snake_pkg.sv
// Shared types and widths for the snake head datapath.
package snake_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_COMMIT = 2'd2
  } stepper_state_e;

  // Left/up move toward zero and go through the subtract path.
  function automatic logic dir_is_sub(dir_e d);
    return d[0];
  endfunction

  function automatic logic dir_is_y(dir_e d);
    return d[1];
  endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// One-bit full adder with its carry flop; carry can be preloaded for subtraction.
module serial_adder_bit (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic carry_init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum_c,
  output logic carry
);

  assign sum_c = a ^ b ^ carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= carry_init;
    end else if (en) begin
      carry <= (a & b) | (carry & (a ^ b));
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Bit-serial head coordinate stepper with screen-edge handling.
// Define SNAKE_WRAP_EN for wrap-around at the edges; default build clamps.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int unsigned STEP   = 10,
  parameter int unsigned X_MAX  = 640,
  parameter int unsigned Y_MAX  = 480,
  parameter int unsigned X_INIT = 320,
  parameter int unsigned Y_INIT = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_valid,
  output logic               step_ready,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic               done,
  output logic               edge_evt
);

  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX - STEP);
  localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX - STEP);
  localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(COORD_W - 1);

  stepper_state_e     state, state_d;
  dir_e               dir_q;
  logic [COORD_W-1:0] op_a, op_b, res;
  logic [CNT_W-1:0]   bit_cnt;
  logic               accept, add_en, commit;
  logic               sum_bit, carry;
  logic               sel_y, sel_sub, edge_hit;
  logic [COORD_W-1:0] lim, bound, new_coord;

  serial_adder_bit u_adder (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .carry_init (dir[0]),
    .en         (add_en),
    .a          (op_a[0]),
    .b          (op_b[0]),
    .sum_c      (sum_bit),
    .carry      (carry)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    add_en  = 1'b0;
    commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step_valid && step_ready) begin
          accept  = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        add_en = 1'b1;
        if (bit_cnt == LAST_BIT) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge detection on the finished sum; a missing carry on subtract is a borrow.
  always_comb begin
    sel_y     = dir_is_y(dir_q);
    sel_sub   = dir_is_sub(dir_q);
    lim       = sel_y ? Y_LIM : X_LIM;
    bound     = sel_y ? Y_MAX_C : X_MAX_C;
    edge_hit  = sel_sub ? ~carry : (carry | (res >= bound));
    new_coord = res;
    if (edge_hit) begin
`ifdef SNAKE_WRAP_EN
      new_coord = sel_sub ? lim : '0;
`else
      new_coord = sel_sub ? '0 : lim;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_x     <= X_INIT_C;
      head_y     <= Y_INIT_C;
      step_ready <= 1'b1;
      done       <= 1'b0;
      edge_evt   <= 1'b0;
      dir_q      <= DIR_RIGHT;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      bit_cnt    <= '0;
    end else begin
      done     <= 1'b0;
      edge_evt <= 1'b0;
      if (accept) begin
        dir_q      <= dir_e'(dir);
        op_a       <= dir[1] ? head_y : head_x;
        op_b       <= dir[0] ? ~STEP_C : STEP_C;
        bit_cnt    <= '0;
        step_ready <= 1'b0;
      end
      // LSB-first: operands shift right, sum bits enter at the top.
      if (add_en) begin
        op_a    <= op_a >> 1;
        op_b    <= op_b >> 1;
        res     <= {sum_bit, res[COORD_W-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (commit) begin
        if (sel_y) head_y <= new_coord;
        else       head_x <= new_coord;
        done       <= 1'b1;
        edge_evt   <= edge_hit;
        step_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper; expectations follow SNAKE_WRAP_EN.
module tb_snake_head_stepper;

  logic       clk;
  logic       reset;
  logic       step_valid;
  logic       step_ready;
  logic [1:0] dir;
  logic [9:0] head_x;
  logic [9:0] head_y;
  logic       done;
  logic       edge_evt;

  int passed = 0;
  int total  = 0;

  snake_head_stepper dut (
    .clk        (clk),
    .reset      (reset),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .dir        (dir),
    .head_x     (head_x),
    .head_y     (head_y),
    .done       (done),
    .edge_evt   (edge_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    step_valid = 1'b0;
    dir        = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one request; return clocks from accept to done and whether ready stayed low.
  task automatic run_step(input logic [1:0] d, output int lat, output logic ready_low_ok);
    step_valid = 1'b1;
    dir        = d;
    tick();
    step_valid   = 1'b0;
    ready_low_ok = (step_ready === 1'b0);
    lat          = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (done === 1'b1) lat = c;
      else if (step_ready !== 1'b0) ready_low_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (head_x !== 10'd320) $display("FAIL reset_x got %0d want 320", head_x); else passed++;
    total++; if (head_y !== 10'd240) $display("FAIL reset_y got %0d want 240", head_y); else passed++;
    total++; if (step_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", step_ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (edge_evt !== 1'b0) $display("FAIL reset_edge got %b want 0", edge_evt); else passed++;
  endtask

  task automatic test_single_step();
    int lat; logic rok;
    run_step(2'b00, lat, rok);
    total++; if (lat !== 11) $display("FAIL step_latency got %0d want 11", lat); else passed++;
    total++; if (rok !== 1'b1) $display("FAIL step_ready_busy got %b want 1", rok); else passed++;
    total++; if (head_x !== 10'd330) $display("FAIL step_x got %0d want 330", head_x); else passed++;
    total++; if (head_y !== 10'd240) $display("FAIL step_y got %0d want 240", head_y); else passed++;
    total++; if (edge_evt !== 1'b0) $display("FAIL step_edge got %b want 0", edge_evt); else passed++;
    total++; if (step_ready !== 1'b1) $display("FAIL step_ready_done got %b want 1", step_ready); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", done); else passed++;
  endtask

  // Request held high with dir toggling during ADD; only accepts at E0 and E12 count.
  task automatic test_back_to_back();
    int n_done, first_done, second_done;
    logic x_stable;
    do_reset();
    n_done = 0; first_done = -1; second_done = -1; x_stable = 1'b1;
    step_valid = 1'b1;
    dir        = 2'b00;
    tick();
    for (int c = 1; c <= 30; c++) begin
      dir = c[0] ? 2'b01 : 2'b00;
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c <= 10 && head_x !== 10'd320) x_stable = 1'b0;
      if (c == 11) begin
        total++; if (head_x !== 10'd330) $display("FAIL b2b_first_x got %0d want 330", head_x); else passed++;
        dir = 2'b00;
      end
      if (c == 23) begin
        total++; if (head_x !== 10'd340) $display("FAIL b2b_second_x got %0d want 340", head_x); else passed++;
        step_valid = 1'b0;
      end
    end
    step_valid = 1'b0;
    total++; if (n_done !== 2) $display("FAIL b2b_done_count got %0d want 2", n_done); else passed++;
    total++; if (first_done !== 11) $display("FAIL b2b_first_done got %0d want 11", first_done); else passed++;
    total++; if (second_done !== 23) $display("FAIL b2b_second_done got %0d want 23", second_done); else passed++;
    total++; if (x_stable !== 1'b1) $display("FAIL b2b_x_stable got %b want 1", x_stable); else passed++;
    total++; if (head_y !== 10'd240) $display("FAIL b2b_y got %0d want 240", head_y); else passed++;
  endtask

  task automatic test_edge_left();
    int lat; logic rok, walk_ok;
    logic [9:0] exp_x;
    do_reset();
    walk_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      run_step(2'b01, lat, rok);
      if (lat != 11 || edge_evt !== 1'b0) walk_ok = 1'b0;
    end
    total++; if (head_x !== 10'd0 || walk_ok !== 1'b1)
      $display("FAIL left_walk got x=%0d ok=%b want x=0 ok=1", head_x, walk_ok); else passed++;
`ifdef SNAKE_WRAP_EN
    exp_x = 10'd630;
`else
    exp_x = 10'd0;
`endif
    run_step(2'b01, lat, rok);
    total++; if (lat !== 11) $display("FAIL left_edge_latency got %0d want 11", lat); else passed++;
    total++; if (head_x !== exp_x) $display("FAIL left_edge_x got %0d want %0d", head_x, exp_x); else passed++;
    total++; if (edge_evt !== 1'b1) $display("FAIL left_edge_evt got %b want 1", edge_evt); else passed++;
    total++; if (head_y !== 10'd240) $display("FAIL left_edge_y got %0d want 240", head_y); else passed++;
  endtask

  task automatic test_edge_down();
    int lat; logic rok, walk_ok;
    logic [9:0] exp_y;
    do_reset();
    walk_ok = 1'b1;
    for (int i = 0; i < 23; i++) begin
      run_step(2'b10, lat, rok);
      if (lat != 11 || edge_evt !== 1'b0) walk_ok = 1'b0;
    end
    total++; if (head_y !== 10'd470 || walk_ok !== 1'b1)
      $display("FAIL down_walk got y=%0d ok=%b want y=470 ok=1", head_y, walk_ok); else passed++;
`ifdef SNAKE_WRAP_EN
    exp_y = 10'd0;
`else
    exp_y = 10'd470;
`endif
    run_step(2'b10, lat, rok);
    total++; if (head_y !== exp_y) $display("FAIL down_edge_y got %0d want %0d", head_y, exp_y); else passed++;
    total++; if (edge_evt !== 1'b1) $display("FAIL down_edge_evt got %b want 1", edge_evt); else passed++;
    total++; if (head_x !== 10'd320) $display("FAIL down_edge_x got %0d want 320", head_x); else passed++;
    tick();
    run_step(2'b11, lat, rok);
`ifdef SNAKE_WRAP_EN
    exp_y = 10'd470;
`else
    exp_y = 10'd460;
`endif
    total++; if (head_y !== exp_y) $display("FAIL up_after_edge_y got %0d want %0d", head_y, exp_y); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, n_done; logic rok;
    do_reset();
    run_step(2'b00, lat, rok);
    total++; if (head_x !== 10'd330) $display("FAIL abort_pre_x got %0d want 330", head_x); else passed++;
    step_valid = 1'b1;
    dir        = 2'b00;
    tick();
    step_valid = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (head_x !== 10'd320 || head_y !== 10'd240)
      $display("FAIL abort_head got (%0d,%0d) want (320,240)", head_x, head_y); else passed++;
    total++; if (step_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", step_ready); else passed++;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    total++; if (n_done !== 0) $display("FAIL abort_no_done got %0d want 0", n_done); else passed++;
    run_step(2'b00, lat, rok);
    total++; if (lat !== 11 || head_x !== 10'd330)
      $display("FAIL abort_recover got lat=%0d x=%0d want lat=11 x=330", lat, head_x); else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    step_valid = 1'b0;
    dir        = 2'b00;
    test_reset();
    test_single_step();
    test_back_to_back();
    test_edge_left();
    test_edge_down();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
